// File: rtl/add_result_collector.sv
// Frame collector for CLA adder results.
// Sums NSAMP {cout,sum} words and counts carries per frame.
module add_result_collector #(
  parameter int NSAMP = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        clr,
  input  logic [31:0] sum,
  input  logic        cout,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] acc_out,
  output logic [7:0]  cout_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(NSAMP - 1);

  state_t      state;
  state_t      state_n;
  logic [39:0] acc;
  logic [7:0]  count;
  logic [7:0]  ccnt;
  logic        xfer;
  logic [39:0] val;

  assign xfer = in_valid & in_ready;
  assign val  = {7'd0, cout, sum};

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode; clr overrides every other event
  always_comb begin
    state_n = state;
    if (clr) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (xfer) state_n = ACCUM;
        ACCUM: if (xfer && count == LAST) state_n = DONE;
        DONE:  if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == DONE): begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Accumulator, sample counter and carry counter
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc   <= '0;
      count <= '0;
      ccnt  <= '0;
    end else if (clr) begin
      acc   <= '0;
      count <= '0;
      ccnt  <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        acc   <= val;
        count <= 8'd1;
        ccnt  <= {7'd0, cout};
      end else begin
        acc   <= acc + val;
        count <= count + 8'd1;
        ccnt  <= ccnt + {7'd0, cout};
      end
    end
  end

  assign acc_out  = acc;
  assign cout_cnt = ccnt;

endmodule

// File: tb/tb_add_result_collector.sv
// Bench for add_result_collector (NSAMP=4).
// Directed steps plus random traffic vs a queue model.
module tb_add_result_collector;

  localparam int NSAMP = 4;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        clr;
  logic [31:0] sum;
  logic        cout;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] acc_out;
  logic [7:0]  cout_cnt;

  int n_tot  = 0;
  int n_pass = 0;

  logic [32:0] q[$];
  bit          m_done;
  logic [39:0] m_acc;
  logic [7:0]  m_cc;

  add_result_collector #(.NSAMP(NSAMP)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .clr      (clr),
    .sum      (sum),
    .cout     (cout),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .cout_cnt (cout_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [39:0] obs,
                     input logic [39:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_done = 0;
    m_acc  = '0;
    m_cc   = '0;
  endtask

  task automatic model_step(input bit v,
                            input logic [31:0] s,
                            input bit c,
                            input bit cl,
                            input bit ordy);
    if (cl) begin
      model_reset();
    end else if (m_done) begin
      if (ordy) m_done = 0;
    end else if (v) begin
      q.push_back({c, s});
      m_acc = '0;
      m_cc  = '0;
      foreach (q[i]) begin
        m_acc += 40'(q[i]);
        m_cc  += 8'(q[i][32]);
      end
      if (q.size() == NSAMP) begin
        m_done = 1;
        q.delete();
      end
    end
  endtask

  task automatic check_model(input string pfx);
    chk({pfx, "_ov"}, 40'(out_valid), 40'(m_done));
    chk({pfx, "_ir"}, 40'(in_ready), 40'(!m_done));
    chk({pfx, "_acc"}, acc_out, m_acc);
    chk({pfx, "_cc"}, 40'(cout_cnt), 40'(m_cc));
  endtask

  task automatic cycle(input bit v,
                       input logic [31:0] s,
                       input bit c,
                       input bit cl,
                       input bit ordy);
    @(negedge CLK);
    check_model("cyc");
    in_valid  = v;
    sum       = s;
    cout      = c;
    clr       = cl;
    out_ready = ordy;
    model_step(v, s, c, cl, ordy);
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    in_valid  = 0;
    sum       = '0;
    cout      = 0;
    clr       = 0;
    out_ready = 0;
  endtask

  task automatic do_reset(input string pfx);
    quiet();
    #2 RESETn = 0;
    #1;
    model_reset();
    chk({pfx, "_ov"}, 40'(out_valid), 40'd0);
    chk({pfx, "_ir"}, 40'(in_ready), 40'd1);
    chk({pfx, "_acc"}, acc_out, 40'd0);
    chk({pfx, "_cc"}, 40'(cout_cnt), 40'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1;
  endtask

  initial begin
    RESETn = 1;
    quiet();
    model_reset();

    // reset asserted between edges, then stay idle
    do_reset("rst");
    repeat (3) cycle(0, 32'hdead, 1, 0, 1);

    // 1,2,3,4 back to back
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0);
    chk("t35_ov", 40'(out_valid), 40'd1);
    chk("t35_acc", acc_out, 40'd10);
    chk("t35_cc", 40'(cout_cnt), 40'd0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // max values with carry
    for (int i = 0; i < 4; i++) cycle(1, 32'hffffffff, 1, 0, 0);
    chk("t36_acc", acc_out, 40'h07fffffffc);
    chk("t36_cc", 40'(cout_cnt), 40'd4);

    // backpressure with in_valid held high
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 1, 0, 0);
    chk("t37_ov", 40'(out_valid), 40'd1);
    chk("t37_acc", acc_out, 40'h07fffffffc);
    chk("t37_cc", 40'(cout_cnt), 40'd4);
    cycle(0, 0, 0, 0, 1);
    chk("t37_idle", 40'(out_valid), 40'd0);

    // bubbles
    cycle(1, 5, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 6, 0, 0, 0);
    cycle(1, 7, 0, 0, 0);
    cycle(1, 8, 0, 0, 0);
    chk("t38_acc", acc_out, 40'd26);
    cycle(0, 0, 0, 0, 1);

    // abort coincident with a valid sample
    cycle(1, 3, 1, 0, 0);
    cycle(1, 4, 0, 0, 0);
    cycle(1, 9, 1, 1, 1);
    chk("t39_acc", acc_out, 40'd0);
    chk("t39_cnt", 40'(dut.count), 40'd0);
    chk("t39_cc", 40'(cout_cnt), 40'd0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    chk("t40_acc", acc_out, 40'd4);
    cycle(0, 0, 0, 0, 1);

    // reset mid-frame then a fresh frame
    cycle(1, 77, 1, 0, 0);
    cycle(1, 88, 0, 0, 0);
    do_reset("mrst");
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    chk("t41_acc", acc_out, 40'd4);
    chk("t41_ov", 40'(out_valid), 40'd1);
    cycle(0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] s;
      bit v, c, cl, r;
      s  = ($urandom_range(0, 3) == 0) ? 32'hffffffff
                                       : $urandom;
      v  = $urandom_range(0, 3) != 0;
      c  = $urandom_range(0, 1) == 1;
      cl = $urandom_range(0, 39) == 0;
      r  = $urandom_range(0, 2) == 0;
      cycle(v, s, c, cl, r);
    end
    cycle(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/add_result_collector.md
ADD_RESULT_COLLECTOR -- requirements
Module: add_result_collector

Interface
REQ-001 Parameter NSAMP, default 4, is the number of adder results per frame; the legal range is 2..128.
REQ-002 Port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port clr, input, 1 bit: synchronous frame abort, active-high.
REQ-005 Port sum, input, 32 bits: result word from the upstream 32-bit CLA adder.
REQ-006 Port cout, input, 1 bit: carry-out from the upstream CLA adder.
REQ-007 Port in_valid, input, 1 bit: sum/cout are valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-009 Port out_valid, output, 1 bit: the frame result on acc_out/cout_cnt is valid.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the frame result.
REQ-011 Port acc_out, output, 40 bits: frame sum of all {cout,sum} values.
REQ-012 Port cout_cnt, output, 8 bits: number of accepted samples in the frame with cout=1.

Function
REQ-013 Each sample's value SHALL be the 33-bit {cout,sum}, zero-extended to 40 bits; accumulation SHALL be unsigned modulo 2^40, which cannot overflow for NSAMP<=128.
REQ-014 An input transfer SHALL occur on a rising CLK edge when in_valid=1 and in_ready=1; cycles with in_valid=0 SHALL NOT count.
REQ-015 The block SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE; it SHALL be decoded from state only.
REQ-017 IDLE, on transfer: acc SHALL load the value, sample count SHALL become 1, cout_cnt SHALL become cout, and the FSM SHALL go to ACCUM.
REQ-018 ACCUM, on transfer: acc SHALL add the value, count SHALL increment, and cout_cnt SHALL add cout; when this is the NSAMP-th transfer the FSM SHALL go to DONE.
REQ-019 ACCUM, with no transfer: all state SHALL hold.
REQ-020 DONE: out_valid SHALL be 1, and acc_out/cout_cnt SHALL hold stable until the handshake completes.
REQ-021 DONE: in_valid SHALL be ignored.
REQ-022 DONE with out_ready=1: the FSM SHALL go to IDLE; out_valid SHALL be 0 from the next cycle.
REQ-023 out_valid SHALL rise on the first cycle after the NSAMP-th transfer, giving a latency of 1 cycle.
REQ-024 The minimum frame period SHALL be NSAMP+1 cycles.
REQ-025 acc_out and cout_cnt SHALL be driven directly from registers.
REQ-026 acc_out and cout_cnt SHALL keep the last frame's values while in IDLE.
REQ-027 clr=1 SHALL take priority over every other event, including a simultaneous transfer or out handshake.
REQ-028 On clr=1, the next state SHALL be IDLE, with acc, count and cout_cnt zeroed and out_valid=0.
REQ-029 out_ready while not in DONE SHALL have no effect.
REQ-030 The sample counter SHALL be 8 bits and SHALL never exceed NSAMP.

Reset
REQ-031 RESETn=0 SHALL immediately, without a clock, force: state=IDLE, acc_out=0, cout_cnt=0, count=0, out_valid=0, in_ready=1.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the first transfer after RESETn rises SHALL start a new frame.
REQ-033 Release of RESETn SHALL take effect at the first rising CLK edge at which RESETn=1.

Verification (NSAMP=4)
REQ-034 Reset: assert RESETn=0 between clock edges -> all outputs 0 at once and in_ready=1; release -> the block stays in IDLE.
REQ-035 Back-to-back sums 1,2,3,4 with cout=0 -> out_valid=1 the cycle after the 4th transfer, acc_out=10, cout_cnt=0.
REQ-036 Four samples of sum=0xFFFFFFFF with cout=1 -> acc_out=0x07FFFFFFFC, cout_cnt=4.
REQ-037 Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> out_valid, acc_out and cout_cnt stable, in_ready=0, no sample absorbed; out_ready=1 -> IDLE next cycle.
REQ-038 Bubbles: samples 5,0(invalid),6,7,8 with in_valid toggled -> acc_out=26 after 4 valid transfers.
REQ-039 Abort: clr=1 after 2 samples and coincident with a valid input -> count=0 and acc=0.
REQ-040 Abort then restart: after the REQ-039 clr, the next 4 samples of value 1 -> acc_out=4.
REQ-041 Mid-frame reset: RESETn=0 after 2 samples -> the REQ-040 result repeats.
